// File: rtl/nw_align_reader.sv
// rtl/nw_align_reader.sv - Needleman-Wunsch path memory reader streaming aligned character pairs.
// Walks the traceback path from (0,0) to (LENGTH-1,LENGTH-1) and emits one pair per legal step.
module nw_align_reader #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8,
  parameter int BYTE_SIZE   = 2 * CORD_LENGTH,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH:0]        path_len,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      raddr,
  input  logic [BYTE_SIZE-1:0]       rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       out_gap1,
  output logic                       out_gap2,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE, ERR} state_t;

  localparam logic [ADDR_WIDTH:0]    MAX_PATH = (ADDR_WIDTH+1)'(2*LENGTH-1);
  localparam logic [CORD_LENGTH-1:0] LEN_C    = CORD_LENGTH'(LENGTH);
  localparam logic [CORD_LENGTH-1:0] LAST_C   = CORD_LENGTH'(LENGTH-1);
  localparam logic [CORD_LENGTH-1:0] ONE_C    = CORD_LENGTH'(1);
  localparam logic [CORD_LENGTH-1:0] ZERO_C   = '0;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, raddr_q;
  logic [CORD_LENGTH-1:0]  px_q, py_q;
  logic                    first_q, rd_en_q;
  logic                    out_valid_q, out_gap1_q, out_gap2_q, out_last_q;
  logic [CWIDTH-1:0]       out_c1_q, out_c2_q;
  logic                    busy_q, done_q, error_q;

  logic [CORD_LENGTH-1:0]  rx, ry, dx, dy;
  logic                    ent_ok, ent_g1, ent_g2, ent_last;
  logic [CWIDTH-1:0]       ent_c1, ent_c2;

  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                input logic [CORD_LENGTH-1:0]   idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int j = 0; j < LENGTH; j++) begin
      if (idx == CORD_LENGTH'(j)) c = str[(LENGTH-1-j)*CWIDTH +: CWIDTH];
    end
    return c;
  endfunction

  // Classify the entry returned by memory against the previous coordinate.
  always_comb begin
    rx       = rdata[BYTE_SIZE-1 -: CORD_LENGTH];
    ry       = rdata[CORD_LENGTH-1:0];
    dx       = rx - px_q;
    dy       = ry - py_q;
    ent_ok   = 1'b1;
    ent_c1   = '0;
    ent_c2   = '0;
    ent_g1   = 1'b0;
    ent_g2   = 1'b0;
    ent_last = (cur_addr_q == '0);
    if (first_q) begin
      if (rx != ZERO_C || ry != ZERO_C) ent_ok = 1'b0;
      ent_c1 = char_at(s1, ZERO_C);
      ent_c2 = char_at(s2, ZERO_C);
    end else if (rx >= LEN_C || ry >= LEN_C) begin
      ent_ok = 1'b0;
    end else if (dx == ONE_C && dy == ONE_C) begin
      ent_c1 = char_at(s1, ry);
      ent_c2 = char_at(s2, rx);
    end else if (dx == ZERO_C && dy == ONE_C) begin
      ent_c1 = char_at(s1, ry);
      ent_g2 = 1'b1;
    end else if (dx == ONE_C && dy == ZERO_C) begin
      ent_g1 = 1'b1;
      ent_c2 = char_at(s2, rx);
    end else begin
      ent_ok = 1'b0;
    end
    if (ent_last && (rx != LAST_C || ry != LAST_C)) ent_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      raddr_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      first_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_c1_q    <= '0;
      out_c2_q    <= '0;
      out_gap1_q  <= 1'b0;
      out_gap2_q  <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (path_len == '0 || path_len > MAX_PATH) begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= ERR;
            end else begin
              cur_addr_q <= path_len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
              raddr_q    <= path_len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
              rd_en_q    <= 1'b1;
              first_q    <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        READ: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (ent_ok) begin
            px_q        <= rx;
            py_q        <= ry;
            first_q     <= 1'b0;
            out_c1_q    <= ent_c1;
            out_c2_q    <= ent_c2;
            out_gap1_q  <= ent_g1;
            out_gap2_q  <= ent_g2;
            out_last_q  <= ent_last;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= ERR;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_c1_q    <= '0;
            out_c2_q    <= '0;
            out_gap1_q  <= 1'b0;
            out_gap2_q  <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_addr_q <= cur_addr_q - ADDR_WIDTH'(1);
              raddr_q    <= cur_addr_q - ADDR_WIDTH'(1);
              rd_en_q    <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        DONE: state_q <= IDLE;
        ERR: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign raddr     = raddr_q;
  assign out_valid = out_valid_q;
  assign out_c1    = out_c1_q;
  assign out_c2    = out_c2_q;
  assign out_gap1  = out_gap1_q;
  assign out_gap2  = out_gap2_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_nw_align_reader.sv
// tb/tb_nw_align_reader.sv - Scoreboard bench for nw_align_reader with LENGTH=4.
module tb_nw_align_reader;

  localparam int LENGTH = 4, CWIDTH = 2, CORD_LENGTH = 8, BYTE_SIZE = 16, ADDR_WIDTH = 5;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic [ADDR_WIDTH:0]      path_len = '0;
  logic [LENGTH*CWIDTH-1:0] s1 = '0, s2 = '0;
  logic                     rd_en;
  logic [ADDR_WIDTH-1:0]    raddr;
  logic [BYTE_SIZE-1:0]     rdata = '0;
  logic                     out_valid, out_ready = 1'b1;
  logic [CWIDTH-1:0]        out_c1, out_c2;
  logic                     out_gap1, out_gap2, out_last, busy, done, error;

  logic [BYTE_SIZE-1:0] mem [32];
  logic [6:0]           exp_q [$];
  int total = 0, bad = 0;
  int rd_cnt = 0, pops = 0, lasts = 0;

  nw_align_reader #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .CORD_LENGTH(CORD_LENGTH),
                    .BYTE_SIZE(BYTE_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .path_len(path_len), .s1(s1), .s2(s2),
    .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_c1(out_c1), .out_c2(out_c2), .out_gap1(out_gap1), .out_gap2(out_gap2),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous-read path memory model.
  always @(posedge clk) begin
    if (rd_en) begin
      rdata  <= mem[raddr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Monitor: compare every presented pair with the scoreboard head, pop on handshake.
  always @(negedge clk) begin
    logic [6:0] got;
    if (!reset && out_valid) begin
      got = {out_c1, out_c2, out_gap1, out_gap2, out_last};
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_pair got=%b expected=none", got);
      end else begin
        if (got !== exp_q[0]) begin
          bad = bad + 1;
          $display("FAIL pair got=%b expected=%b", got, exp_q[0]);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops = pops + 1;
          if (out_last) lasts = lasts + 1;
        end
      end
    end
  end

  function automatic logic [6:0] mk(input int c1, input int c2, input bit g1, input bit g2, input bit l);
    return {2'(c1), 2'(c2), g1, g2, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_entry(input int addr, input int x, input int y);
    mem[addr] = {8'(x), 8'(y)};
  endtask

  task automatic do_start(input int len);
    @(posedge clk); #1;
    path_len = (ADDR_WIDTH+1)'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done || error) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({name, "_finished"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({name, "_valid_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic load_diag();
    s1 = 8'h1B; s2 = 8'h1B;
    set_entry(0, 3, 3); set_entry(1, 2, 2); set_entry(2, 1, 1); set_entry(3, 0, 0);
  endtask

  task automatic push_diag();
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0, 0));
    exp_q.push_back(mk(2, 2, 0, 0, 0));
    exp_q.push_back(mk(3, 3, 0, 0, 1));
  endtask

  initial begin
    int rd0, pop0, last0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({rd_en, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2,
                              out_last, busy, done, error}), 32'd0);
    reset = 1'b0;

    // Diagonal path, with first-valid latency check.
    load_diag(); push_diag();
    rd0 = rd_cnt; pop0 = pops;
    do_start(4);
    chk("diag_busy", 32'(busy), 32'd1);
    chk("diag_lat_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("diag_lat_c2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("diag_lat_c3", 32'(out_valid), 32'd1);
    wait_end("diag");
    chk("diag_done", 32'({done, error, busy}), 32'b100);
    chk("diag_reads", 32'(rd_cnt - rd0), 32'd4);
    chk("diag_pairs", 32'(pops - pop0), 32'd4);

    // Gapped path.
    s1 = 8'h1B; s2 = 8'hE4;
    set_entry(0, 3, 3); set_entry(1, 2, 3); set_entry(2, 1, 2); set_entry(3, 1, 1); set_entry(4, 0, 0);
    exp_q.push_back(mk(0, 3, 0, 0, 0));
    exp_q.push_back(mk(1, 2, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 1, 0));
    exp_q.push_back(mk(3, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 1));
    rd0 = rd_cnt; pop0 = pops;
    do_start(5);
    wait_end("gap");
    chk("gap_done", 32'({done, error}), 32'b10);
    chk("gap_reads", 32'(rd_cnt - rd0), 32'd5);
    chk("gap_pairs", 32'(pops - pop0), 32'd5);

    // Backpressure on the second pair.
    load_diag(); push_diag();
    rd0 = rd_cnt; pop0 = pops;
    do_start(4);
    for (int i = 0; i < 20; i++) begin
      if (pops - pop0 >= 1) break;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("bp_first_accepted", 32'(pops - pop0), 32'd1);
    wait_valid("bp");
    repeat (5) @(posedge clk);
    #1;
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    chk("bp_no_extra_read", 32'(rd_cnt - rd0), 32'd2);
    out_ready = 1'b1;
    wait_end("bp");
    chk("bp_done", 32'({done, error}), 32'b10);
    chk("bp_pairs", 32'(pops - pop0), 32'd4);
    chk("bp_reads", 32'(rd_cnt - rd0), 32'd4);

    // Illegal step (0,0) -> (2,2).
    s1 = 8'h1B; s2 = 8'h1B;
    set_entry(0, 3, 3); set_entry(1, 2, 2); set_entry(2, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    pop0 = pops;
    do_start(3);
    wait_end("illegal");
    chk("illegal_flags", 32'({done, error, busy, out_valid}), 32'b0100);
    repeat (6) @(posedge clk);
    #1;
    chk("illegal_pairs", 32'(pops - pop0), 32'd1);
    chk("illegal_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length path.
    rd0 = rd_cnt;
    do_start(0);
    chk("len0_error", 32'({error, busy, done}), 32'b100);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_no_read", 32'(rd_cnt - rd0), 32'd0);

    // Wrong endpoint at address 0.
    load_diag();
    set_entry(0, 2, 3);
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0, 0));
    exp_q.push_back(mk(2, 2, 0, 0, 0));
    pop0 = pops; last0 = lasts;
    do_start(4);
    wait_end("endpt");
    chk("endpt_flags", 32'({done, error}), 32'b01);
    chk("endpt_pairs", 32'(pops - pop0), 32'd3);
    chk("endpt_no_last", 32'(lasts - last0), 32'd0);

    // Reset while stalled in EMIT, then a clean rerun.
    load_diag(); push_diag();
    out_ready = 1'b0;
    do_start(4);
    wait_valid("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", 32'({rd_en, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2,
                            out_last, busy, done, error}), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    push_diag();
    out_ready = 1'b1;
    pop0 = pops;
    do_start(4);
    wait_end("rerun");
    chk("rerun_done", 32'({done, error}), 32'b10);
    chk("rerun_pairs", 32'(pops - pop0), 32'd4);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
